// File: rtl/mic_pkg.sv
// Shared constants and types for the Pmod MIC SPI receiver.
package mic_pkg;

    localparam int DEF_SCK_DIV       = 20;
    localparam int DEF_FRAME_BITS    = 16;
    localparam int DEF_DATA_BITS     = 12;
    localparam int DEF_SAMPLE_PERIOD = 2268;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEAD    = 3'd1,
        SHIFT   = 3'd2,
        TRAIL   = 3'd3,
        CAPTURE = 3'd4
    } mic_state_t;

    typedef logic [DEF_DATA_BITS-1:0] sample_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals crossing into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mic_spi_rx.sv
// SPI master reading the Pmod MIC ADC and presenting samples on valid/ready.
// Optional leading-bit frame check enabled by defining MIC_SPI_FRAME_CHECK_EN.
module mic_spi_rx
    import mic_pkg::*;
#(
    parameter int SCK_DIV       = DEF_SCK_DIV,
    parameter int FRAME_BITS    = DEF_FRAME_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 miso,
    output logic                 cs_n,
    output logic                 sclk,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic                 busy
`ifdef MIC_SPI_FRAME_CHECK_EN
    ,
    output logic                 frame_err
`endif
);

    localparam int PER_W = $clog2(SAMPLE_PERIOD);
    localparam int DIV_W = $clog2(SCK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);
`ifdef MIC_SPI_FRAME_CHECK_EN
    localparam int SHIFT_W = FRAME_BITS;
`else
    // Leading bits are never looked at, so they are simply shifted out the top.
    localparam int SHIFT_W = DATA_BITS;
`endif

    mic_state_t         state;
    logic [PER_W-1:0]   period_cnt;
    logic [DIV_W-1:0]   phase_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SHIFT_W-1:0] shift_q;
    logic               miso_s;
    logic               start;
    logic               phase_last;
    logic               shift_en;
    logic               frame_ok;
    logic               capture;

    sync_2ff #(.WIDTH(1)) u_sync_miso (
        .clk (clk),
        .rst (rst),
        .d   (miso),
        .q   (miso_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt <= '0;
        end else if (!en) begin
            period_cnt <= '0;
        end else if (period_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign start      = en && (period_cnt == '0);
    assign phase_last = (phase_cnt == DIV_W'(SCK_DIV - 1));
    // The sclk register doubles as the half-bit indicator inside SHIFT.
    assign shift_en   = (state == SHIFT) && !sclk && phase_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            sclk      <= 1'b1;
            busy      <= 1'b0;
            phase_cnt <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    phase_cnt <= '0;
                    bit_cnt   <= '0;
                    if (start) begin
                        state <= LEAD;
                        cs_n  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LEAD: begin
                    if (phase_last) begin
                        state     <= SHIFT;
                        sclk      <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!phase_last) begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end else begin
                        phase_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            state <= TRAIL;
                        end else begin
                            sclk    <= 1'b0;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (phase_last) begin
                        state     <= CAPTURE;
                        cs_n      <= 1'b1;
                        busy      <= 1'b0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cs_n  <= 1'b1;
                    sclk  <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (shift_en) begin
            shift_q <= {shift_q[SHIFT_W-2:0], miso_s};
        end
    end

`ifdef MIC_SPI_FRAME_CHECK_EN
    assign frame_ok = ~|shift_q[FRAME_BITS-1:DATA_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= (state == CAPTURE) && !frame_ok;
        end
    end
`else
    assign frame_ok = 1'b1;
`endif

    assign capture = (state == CAPTURE) && frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (capture) begin
                sample       <= shift_q[DATA_BITS-1:0];
                sample_valid <= 1'b1;
                if (sample_valid && !sample_ready) begin
                    overrun <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mic_spi_rx.sv
// Directed bench for mic_spi_rx with a behavioural Pmod MIC ADC model.
module tb_mic_spi_rx;
    import mic_pkg::*;

    localparam int SCK_DIV    = DEF_SCK_DIV;
    localparam int FRAME_BITS = DEF_FRAME_BITS;
    localparam int PERIOD     = DEF_SAMPLE_PERIOD;
    localparam int BIT_T      = 2 * SCK_DIV;
    localparam int CS_TO_VLD  = SCK_DIV + FRAME_BITS * BIT_T + SCK_DIV + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        miso = 1'b0;
    logic        sample_ready;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        overrun;
    logic        busy;
`ifdef MIC_SPI_FRAME_CHECK_EN
    logic        frame_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] adc_word = 16'h0000;
    int fcnt = 0;

    typedef struct {
        logic [15:0] word;
        logic        ready;
        logic [11:0] exp_sample;
        logic        exp_ov;
    } vec_t;
    vec_t vec[5];

    mic_spi_rx dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .miso         (miso),
        .cs_n         (cs_n),
        .sclk         (sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .busy         (busy)
`ifdef MIC_SPI_FRAME_CHECK_EN
        ,
        .frame_err    (frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC presents the next frame bit on each sclk fall while selected.
    always @(negedge cs_n) fcnt = 0;
    always @(negedge sclk) begin
        if (!cs_n) begin
            if (fcnt < 16) miso = adc_word[15 - fcnt];
            fcnt = fcnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cs(input logic lvl, input string name);
        int n = 0;
        while (cs_n !== lvl && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (cs_n !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout cs_n=%b required=%b", name, cs_n, lvl);
        end
    endtask

    task automatic count_rises(input int target, input string name);
        int n = 0;
        int r = 0;
        logic prev = sclk;
        while (r < target && n < 2000) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) r++;
            prev = sclk;
        end
        if (r < target) begin
            checks++;
            errors++;
            $display("FAIL %s timeout rises=%0d required=%0d", name, r, target);
        end
    endtask

    initial begin
        int t0;
        int last_rise;
        int rises;
        int bad_gap;
        int n;
        int falls;
        logic prev;

        vec[0] = '{16'h0000, 1'b1, 12'h000, 1'b0};
        vec[1] = '{16'h0FFF, 1'b1, 12'hFFF, 1'b0};
        vec[2] = '{16'h0555, 1'b1, 12'h555, 1'b0};
        vec[3] = '{16'h0123, 1'b0, 12'h123, 1'b0};
        vec[4] = '{16'h0456, 1'b0, 12'h456, 1'b1};

        // Reset state and first frame timing
        rst = 1'b1; en = 1'b1; sample_ready = 1'b0; adc_word = 16'h0ABC;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 1);
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("cs_fall_first_cycle", cs_n, 0);
        chk("busy_in_frame", busy, 1);
        t0 = cyc; last_rise = cyc; rises = 0; bad_gap = 0; n = 0; prev = sclk;
        while (!sample_valid && n < 3000) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) begin
                rises++;
                if (cyc - last_rise != BIT_T) bad_gap++;
                last_rise = cyc;
            end
            prev = sclk;
        end
        chk("valid_seen", sample_valid, 1);
        chk("sclk_rise_count", rises, FRAME_BITS);
        chk("sclk_rise_spacing_errs", bad_gap, 0);
        chk("cs_to_valid", cyc - t0, CS_TO_VLD);
        chk("last_rise_to_valid", cyc - last_rise, BIT_T + 1);
        chk("first_sample", sample, 12'hABC);
        sample_ready = 1'b1;
        wait_cs(1'b0, "second_frame");
        chk("frame_period", cyc - t0, PERIOD);
        wait_cs(1'b1, "second_frame_end");

        // Table of frames: consumed, held, and overwritten samples
        for (int i = 0; i < 5; i++) begin
            adc_word = vec[i].word;
            sample_ready = vec[i].ready;
            wait_cs(1'b0, "vec_start");
            wait_cs(1'b1, "vec_end");
            @(negedge clk);
            chk($sformatf("vec%0d_sample", i), sample, vec[i].exp_sample);
            chk($sformatf("vec%0d_valid", i), sample_valid, 1);
            chk($sformatf("vec%0d_overrun", i), overrun, vec[i].exp_ov);
            if (vec[i].ready) begin
                @(negedge clk);
                chk($sformatf("vec%0d_valid_one_cycle", i), sample_valid, 0);
            end
        end
        sample_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("ovr_valid_drained", sample_valid, 0);
        repeat (5) @(negedge clk);
        chk("ovr_sticky", overrun, 1);

        // Reset in the middle of bit 7
        wait_cs(1'b0, "rst_frame_start");
        count_rises(7, "rst_frame_bits");
        repeat (SCK_DIV + 5) @(negedge clk);
        chk("pre_rst_sclk_low", sclk, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_sclk", sclk, 1);
        chk("mid_rst_valid", sample_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        repeat (3) @(negedge clk);
        adc_word = 16'h0321;
        rst = 1'b0;
        wait_cs(1'b0, "post_rst_start");
        wait_cs(1'b1, "post_rst_end");
        @(negedge clk);
        chk("post_rst_sample", sample, 12'h321);
        chk("post_rst_valid", sample_valid, 1);

        // en dropped during bit 3
        adc_word = 16'h0777;
        wait_cs(1'b0, "en_frame_start");
        count_rises(3, "en_frame_bits");
        en = 1'b0;
        wait_cs(1'b1, "en_frame_end");
        @(negedge clk);
        chk("en_drop_sample", sample, 12'h777);
        chk("en_drop_valid", sample_valid, 1);
        falls = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!cs_n) falls++;
        end
        chk("en_low_no_frame", falls, 0);
        adc_word = 16'h8ABC;
        en = 1'b1;
        @(negedge clk);
        chk("en_rise_starts_frame", cs_n, 0);

        // Nonzero leading bit
        wait_cs(1'b1, "lead_bit_end");
        @(negedge clk);
`ifdef MIC_SPI_FRAME_CHECK_EN
        chk("frame_err_pulse", frame_err, 1);
        chk("frame_err_valid", sample_valid, 0);
        chk("frame_err_sample_kept", sample, 12'h777);
        @(negedge clk);
        chk("frame_err_one_cycle", frame_err, 0);
`else
        chk("lead_ignored_sample", sample, 12'hABC);
        chk("lead_ignored_valid", sample_valid, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
